// File: rtl/qram_pkg.sv
// Shared types for the serial-access RAM: FSM states, opcodes and counter sizing.
// Nothing here depends on the data width.
package qram_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StXfer = 2'd2,
    StDone = 2'd3
  } qramState_t;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } qramOp_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qram_shift_cell.sv
// Loadable MSB-first shift register.
// It serves both as the serial-to-parallel and as the parallel-to-serial converter.
module qram_shift_cell
  import qram_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             Clock,
  input  logic             shiftEn,
  input  logic             loadEn,
  input  logic             serialIn,
  input  logic [Width-1:0] loadValue,
  output logic [Width-1:0] value
);

  // The truncating cast keeps {value[Width-2:0], serialIn} and stays legal when Width is 1.
  always_ff @(posedge Clock) begin
    if (loadEn) begin
      value <= loadValue;
    end else if (shiftEn) begin
      value <= Width'({value, serialIn});
    end
  end

endmodule

// File: rtl/qram_array.sv
// Serial-access RAM. An access sends a serial start address, then moves BurstLen words of
// serial data in MSB-first order. The word address increments after each word and wraps at Depth.
module qram_array
  import qram_pkg::*;
#(
  parameter int AddrWidth = 4,
  parameter int DataWidth = 8,
  parameter int BurstLen  = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Read,
  input  logic Write,
  input  logic AddressQBit,
  input  logic inputQBit,
  output logic outputQBit,
  output logic outputValid,
  output logic Busy,
  output logic Done,
  output logic Error
);

  localparam int Depth = 1 << AddrWidth;
  localparam int AcW   = cntWidth(AddrWidth);
  localparam int BcW   = cntWidth(DataWidth);
  localparam int WcW   = cntWidth(BurstLen);

  localparam logic [AcW-1:0] AddrCntLast = AcW'(AddrWidth - 1);
  localparam logic [BcW-1:0] BitCntLast  = BcW'(DataWidth - 1);
  localparam logic [WcW-1:0] WordCntLast = WcW'(BurstLen - 1);

  qramState_t state;
  qramOp_t    op;
  logic [AcW-1:0] addrCnt;
  logic [BcW-1:0] bitCnt;
  logic [WcW-1:0] wordCnt;
  logic           errPulse;

  logic [DataWidth-1:0] mem [Depth];

  logic [AddrWidth-1:0] addrValue;
  logic [AddrWidth-1:0] addrComplete;
  logic [AddrWidth-1:0] addrIncr;
  logic [DataWidth-1:0] dataValue;
  logic [DataWidth-1:0] dataWord;
  logic [DataWidth-1:0] readWord;

  logic    startReq;
  qramOp_t startOp;
  qramOp_t xferOp;
  logic    addrDone;
  logic    inXfer;
  logic    wordEnd;
  logic    lastWord;
  logic    commit;
  logic    addrShiftEn;
  logic    dataLoadEn;

  assign startReq = (state == StIdle) && (Read ^ Write);
  assign startOp  = Write ? OpWrite : OpRead;

  // With a one-bit address the strobe cycle is also the last address cycle.
  assign addrDone = ((state == StAddr) && (addrCnt == AddrCntLast)) ||
                    (startReq && (AddrWidth == 1));
  assign xferOp   = (state == StIdle) ? startOp : op;

  assign inXfer   = (state == StXfer);
  assign wordEnd  = inXfer && (bitCnt == BitCntLast);
  assign lastWord = (wordCnt == WordCntLast);

  // Address and word values including the bit sampled in the current cycle.
  assign addrComplete = AddrWidth'({addrValue, AddressQBit});
  assign addrIncr     = addrValue + AddrWidth'(1);
  assign dataWord     = DataWidth'({dataValue, inputQBit});
  assign readWord     = addrDone ? mem[addrComplete] : mem[addrIncr];

  // A word still being shifted when Reset arrives is discarded.
  assign commit      = wordEnd && (op == OpWrite) && !Reset;
  assign addrShiftEn = startReq || (state == StAddr);
  assign dataLoadEn  = (addrDone && (xferOp == OpRead)) || (wordEnd && (op == OpRead));

  qram_shift_cell #(.Width(AddrWidth)) addrCell (
    .Clock     (Clock),
    .shiftEn   (addrShiftEn),
    .loadEn    (wordEnd),
    .serialIn  (AddressQBit),
    .loadValue (addrIncr),
    .value     (addrValue)
  );

  qram_shift_cell #(.Width(DataWidth)) dataCell (
    .Clock     (Clock),
    .shiftEn   (inXfer),
    .loadEn    (dataLoadEn),
    .serialIn  (inputQBit),
    .loadValue (readWord),
    .value     (dataValue)
  );

  always_ff @(posedge Clock) begin
    if (commit) begin
      mem[addrValue] <= dataWord;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= StIdle;
      op       <= OpRead;
      addrCnt  <= '0;
      bitCnt   <= '0;
      wordCnt  <= '0;
      errPulse <= 1'b0;
    end else begin
      errPulse <= (state == StIdle) && Read && Write;
      case (state)
        StIdle: begin
          if (startReq) begin
            op      <= startOp;
            addrCnt <= AcW'(1);
            bitCnt  <= '0;
            wordCnt <= '0;
            state   <= (AddrWidth == 1) ? StXfer : StAddr;
          end
        end
        StAddr: begin
          if (addrCnt == AddrCntLast) begin
            state <= StXfer;
          end else begin
            addrCnt <= addrCnt + AcW'(1);
          end
        end
        StXfer: begin
          if (bitCnt == BitCntLast) begin
            bitCnt <= '0;
            if (lastWord) begin
              state <= StDone;
            end else begin
              wordCnt <= wordCnt + WcW'(1);
            end
          end else begin
            bitCnt <= bitCnt + BcW'(1);
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign Busy        = (state != StIdle);
  assign Done        = (state == StDone);
  assign Error       = errPulse;
  assign outputValid = inXfer && (op == OpRead);
  assign outputQBit  = outputValid & dataValue[DataWidth-1];

endmodule
